// File: rtl/instruction_fetch_unit_pkg.sv
// rtl/instruction_fetch_unit_pkg.sv - shared rv32 fetch-stage types and constants
package instruction_fetch_unit_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT,
        FETCH,
        DRAIN
    } fetch_state_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// rtl/instruction_fetch_unit_if.sv - fetch unit control, instruction memory and IF/ID bundle
interface instruction_fetch_unit_if;
    import instruction_fetch_unit_pkg::*;

    logic            STALL;
    logic            BRANCH_TAKEN;
    logic [XLEN-1:0] BRANCH_TARGET;
    logic            IMEM_READ;
    logic [XLEN-1:0] IMEM_ADDRESS;
    logic [XLEN-1:0] IMEM_READDATA;
    logic            IMEM_BUSYWAIT;
    logic [XLEN-1:0] PC_OUT;
    logic [XLEN-1:0] PC_PLUS_FOUR_OUT;
    logic [XLEN-1:0] INSTRUCTION_OUT;
    logic            FETCH_BUSYWAIT;

    modport master (
        input  STALL, BRANCH_TAKEN, BRANCH_TARGET, IMEM_READDATA, IMEM_BUSYWAIT,
        output IMEM_READ, IMEM_ADDRESS, PC_OUT, PC_PLUS_FOUR_OUT, INSTRUCTION_OUT,
               FETCH_BUSYWAIT
    );

    modport slave (
        output STALL, BRANCH_TAKEN, BRANCH_TARGET, IMEM_READDATA, IMEM_BUSYWAIT,
        input  IMEM_READ, IMEM_ADDRESS, PC_OUT, PC_PLUS_FOUR_OUT, INSTRUCTION_OUT,
               FETCH_BUSYWAIT
    );

endinterface

// File: rtl/instruction_fetch_unit_fetch_pc_reg.sv
// rtl/instruction_fetch_unit_fetch_pc_reg.sv - program counter with reset vector, +4 and redirect
module fetch_pc_reg
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            advance,
    input  logic            redirect,
    input  logic [XLEN-1:0] target,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus_four
);

    assign pc_plus_four = pc + XLEN'(4);

    // Redirect outranks advance so a taken branch never loses to a same-cycle fetch.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            pc <= RESET_VECTOR;
        end else if (redirect) begin
            pc <= word_align(target);
        end else if (advance) begin
            pc <= pc_plus_four;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - IF stage: PC ownership, imem handshake, IF/ID output register
module instruction_fetch_unit #(
    parameter logic [instruction_fetch_unit_pkg::XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [instruction_fetch_unit_pkg::XLEN-1:0] NOP_INSTR    =
        instruction_fetch_unit_pkg::NOP_INSTR
) (
    input  logic                      CLK,
    input  logic                      RESET,
    instruction_fetch_unit_if.master  bus
);
    import instruction_fetch_unit_pkg::*;

    fetch_state_t    state;
    logic            out_valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus_four;
    logic [XLEN-1:0] drain_addr;
    logic [XLEN-1:0] pc_out;
    logic [XLEN-1:0] pc_plus_four_out;
    logic [XLEN-1:0] instruction_out;
    logic            accept;

    assign accept = (state == FETCH) && !bus.BRANCH_TAKEN && !bus.IMEM_BUSYWAIT &&
                    (!out_valid || !bus.STALL);

    fetch_pc_reg #(.RESET_VECTOR(RESET_VECTOR)) u_pc (
        .CLK          (CLK),
        .RESET        (RESET),
        .advance      (accept),
        .redirect     (bus.BRANCH_TAKEN),
        .target       (bus.BRANCH_TARGET),
        .pc           (pc),
        .pc_plus_four (pc_plus_four)
    );

    assign bus.IMEM_READ        = (state != BOOT);
    assign bus.IMEM_ADDRESS     = (state == DRAIN) ? drain_addr : pc;
    assign bus.FETCH_BUSYWAIT   = ~out_valid;
    assign bus.PC_OUT           = pc_out;
    assign bus.PC_PLUS_FOUR_OUT = pc_plus_four_out;
    assign bus.INSTRUCTION_OUT  = instruction_out;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state            <= BOOT;
            out_valid        <= 1'b0;
            drain_addr       <= RESET_VECTOR;
            pc_out           <= '0;
            pc_plus_four_out <= '0;
            instruction_out  <= NOP_INSTR;
        end else if (bus.BRANCH_TAKEN) begin
            out_valid       <= 1'b0;
            instruction_out <= NOP_INSTR;
            // An in-flight wrong-path read must finish on its original address.
            case (state)
                FETCH: begin
                    if (bus.IMEM_BUSYWAIT) begin
                        state      <= DRAIN;
                        drain_addr <= pc;
                    end
                end
                DRAIN:   state <= DRAIN;
                default: state <= FETCH;
            endcase
        end else begin
            case (state)
                BOOT: state <= FETCH;
                FETCH: begin
                    if (accept) begin
                        out_valid        <= 1'b1;
                        pc_out           <= pc;
                        pc_plus_four_out <= pc_plus_four;
                        instruction_out  <= bus.IMEM_READDATA;
                    end else if (!bus.STALL) begin
                        out_valid <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (!bus.IMEM_BUSYWAIT) begin
                        state <= FETCH;
                    end
                end
                default: state <= BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - self-checking bench for instruction_fetch_unit
module tb_instruction_fetch_unit;

    localparam logic [31:0] K   = 32'hA5A5_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic CLK = 1'b0;
    logic RESET = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    instruction_fetch_unit_if bus ();

    instruction_fetch_unit dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    assign bus.IMEM_READDATA = bus.IMEM_ADDRESS ^ K;

    typedef struct {
        logic        stall;
        logic        busy;
        logic        br;
        logic [31:0] tgt;
        logic        exp_read;
        logic [31:0] exp_addr;
        logic        exp_fbw;
        logic [31:0] exp_pc;
        logic [31:0] exp_pc4;
        logic [31:0] exp_instr;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic stall, input logic busy, input logic br,
                       input logic [31:0] tgt, input logic rd, input logic [31:0] addr,
                       input logic fbw, input logic [31:0] pc, input logic [31:0] pc4,
                       input logic [31:0] instr);
        vec_t v;
        v.stall = stall; v.busy = busy; v.br = br; v.tgt = tgt;
        v.exp_read = rd; v.exp_addr = addr; v.exp_fbw = fbw;
        v.exp_pc = pc; v.exp_pc4 = pc4; v.exp_instr = instr;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic stall, input logic busy, input logic br,
                         input logic [31:0] tgt);
        bus.STALL = stall;
        bus.IMEM_BUSYWAIT = busy;
        bus.BRANCH_TAKEN = br;
        bus.BRANCH_TARGET = tgt;
    endtask

    initial begin
        logic [31:0] exp_pc;
        logic        br_prev;
        logic        busy_read_prev;
        logic [31:0] addr_prev;
        int          handoffs;
        logic        stall, busy, br;
        logic [31:0] tgt;

        drive(0, 0, 0, 32'h0);

        //  stall busy br target        read addr          fbw pc            pc4           instr
        add(0, 0, 0, 32'h0,          0, 32'h0,         1, 32'h0,         32'h0,        NOP);
        add(0, 0, 0, 32'h0,          1, 32'h0,         1, 32'h0,         32'h0,        NOP);
        add(0, 0, 0, 32'h0,          1, 32'h4,         0, 32'h0,         32'h4,        K ^ 32'h0);
        add(1, 0, 0, 32'h0,          1, 32'h8,         0, 32'h4,         32'h8,        K ^ 32'h4);
        add(1, 0, 0, 32'h0,          1, 32'h8,         0, 32'h4,         32'h8,        K ^ 32'h4);
        add(0, 0, 0, 32'h0,          1, 32'h8,         0, 32'h4,         32'h8,        K ^ 32'h4);
        add(0, 1, 0, 32'h0,          1, 32'hC,         0, 32'h8,         32'hC,        K ^ 32'h8);
        add(0, 1, 0, 32'h0,          1, 32'hC,         1, 32'h8,         32'hC,        K ^ 32'h8);
        add(0, 1, 0, 32'h0,          1, 32'hC,         1, 32'h8,         32'hC,        K ^ 32'h8);
        add(0, 0, 0, 32'h0,          1, 32'hC,         1, 32'h8,         32'hC,        K ^ 32'h8);
        add(0, 1, 1, 32'h103,        1, 32'h10,        0, 32'hC,         32'h10,       K ^ 32'hC);
        add(0, 1, 0, 32'h0,          1, 32'h10,        1, 32'hC,         32'h10,       NOP);
        add(0, 0, 0, 32'h0,          1, 32'h10,        1, 32'hC,         32'h10,       NOP);
        add(0, 0, 0, 32'h0,          1, 32'h100,       1, 32'hC,         32'h10,       NOP);
        add(1, 0, 1, 32'h200,        1, 32'h104,       0, 32'h100,       32'h104,      K ^ 32'h100);
        add(0, 1, 1, 32'h300,        1, 32'h200,       1, 32'h100,       32'h104,      NOP);
        add(0, 1, 1, 32'h400,        1, 32'h200,       1, 32'h100,       32'h104,      NOP);
        add(0, 0, 0, 32'h0,          1, 32'h200,       1, 32'h100,       32'h104,      NOP);
        add(0, 0, 0, 32'h0,          1, 32'h400,       1, 32'h100,       32'h104,      NOP);
        add(0, 0, 1, 32'hFFFF_FFFF,  1, 32'h404,       0, 32'h400,       32'h404,      K ^ 32'h400);
        add(0, 0, 0, 32'h0,          1, 32'hFFFF_FFFC, 1, 32'h400,       32'h404,      NOP);
        add(0, 0, 0, 32'h0,          1, 32'h0,         0, 32'hFFFF_FFFC, 32'h0,        K ^ 32'hFFFF_FFFC);
        add(0, 0, 0, 32'h0,          1, 32'h4,         0, 32'h0,         32'h4,        K ^ 32'h0);

        repeat (2) @(negedge CLK);
        RESET = 1'b1;
        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            if (i > 0) @(negedge CLK);
            check($sformatf("v%0d read", i), 32'(bus.IMEM_READ), 32'(vecs[i].exp_read));
            if (vecs[i].exp_read)
                check($sformatf("v%0d addr", i), bus.IMEM_ADDRESS, vecs[i].exp_addr);
            check($sformatf("v%0d fbw", i), 32'(bus.FETCH_BUSYWAIT), 32'(vecs[i].exp_fbw));
            check($sformatf("v%0d pc", i), bus.PC_OUT, vecs[i].exp_pc);
            check($sformatf("v%0d pc4", i), bus.PC_PLUS_FOUR_OUT, vecs[i].exp_pc4);
            check($sformatf("v%0d instr", i), bus.INSTRUCTION_OUT, vecs[i].exp_instr);
            drive(vecs[i].stall, vecs[i].busy, vecs[i].br, vecs[i].tgt);
        end

        // Asynchronous reset in the middle of a waited access.
        @(negedge CLK);
        drive(0, 1, 0, 32'h0);
        repeat (2) @(negedge CLK);
        #2;
        RESET = 1'b0;
        #1;
        check("rst read", 32'(bus.IMEM_READ), 32'h0);
        check("rst fbw", 32'(bus.FETCH_BUSYWAIT), 32'h1);
        check("rst pc", bus.PC_OUT, 32'h0);
        check("rst pc4", bus.PC_PLUS_FOUR_OUT, 32'h0);
        check("rst instr", bus.INSTRUCTION_OUT, NOP);
        @(negedge CLK);
        drive(0, 0, 0, 32'h0);
        RESET = 1'b1;
        #1;
        check("boot read", 32'(bus.IMEM_READ), 32'h0);
        @(negedge CLK);
        check("restart read", 32'(bus.IMEM_READ), 32'h1);
        check("restart addr", bus.IMEM_ADDRESS, 32'h0);
        @(negedge CLK);
        check("restart pc", bus.PC_OUT, 32'h0);
        check("restart fbw", 32'(bus.FETCH_BUSYWAIT), 32'h0);

        // Randomized run against a program-order model of the handed-off stream.
        RESET = 1'b0;
        @(negedge CLK);
        RESET = 1'b1;
        exp_pc = 32'h0;
        br_prev = 1'b0;
        busy_read_prev = 1'b0;
        addr_prev = 32'h0;
        handoffs = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge CLK);
            if (br_prev) begin
                check("rnd flush fbw", 32'(bus.FETCH_BUSYWAIT), 32'h1);
                check("rnd flush instr", bus.INSTRUCTION_OUT, NOP);
            end
            if (busy_read_prev && bus.IMEM_READ)
                check("rnd addr stable", bus.IMEM_ADDRESS, addr_prev);
            stall = ($urandom % 4) == 0;
            busy  = ($urandom % 10) < 3;
            br    = ($urandom % 20) == 0;
            tgt   = $urandom;
            if (($urandom % 4) == 0) tgt = 32'hFFFF_FFF0 | ($urandom % 16);
            drive(stall, busy, br, tgt);
            if (!bus.FETCH_BUSYWAIT && !stall) begin
                check("rnd pc", bus.PC_OUT, exp_pc);
                check("rnd pc4", bus.PC_PLUS_FOUR_OUT, exp_pc + 32'd4);
                check("rnd instr", bus.INSTRUCTION_OUT, exp_pc ^ K);
                exp_pc = exp_pc + 32'd4;
                handoffs++;
            end
            if (br) exp_pc = {tgt[31:2], 2'b00};
            br_prev = br;
            busy_read_prev = bus.IMEM_READ && busy;
            addr_prev = bus.IMEM_ADDRESS;
        end
        drive(0, 0, 0, 32'h0);
        check("rnd progress", 32'(handoffs >= 300), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
